// File: rtl/object_motion.sv
// object_motion: moves NUM_OBJ sprites from USB keycodes once per video frame.
// Ports: Clk, Reset_n (async low), vsync, keycodes -> frame_tick, obj_x/obj_y/obj_state.
// Optional macro OBJ_COLLISION_EN blocks horizontal moves into other objects.
module object_motion #(
  parameter int NUM_OBJ  = 2,
  parameter int KEYS     = 4,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_GROUND = 479,
  parameter int OBJ_W    = 64,
  parameter int OBJ_H    = 96,
  parameter int STEP_X   = 2,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter logic [24*NUM_OBJ-1:0] KEY_MAP =
    {8'h52, 8'h50, 8'h4F, 8'h1A, 8'h04, 8'h07}
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  vsync,
  input  logic [8*KEYS-1:0]     keycodes,
  output logic                  frame_tick,
  output logic [10*NUM_OBJ-1:0] obj_x,
  output logic [10*NUM_OBJ-1:0] obj_y,
  output logic [2*NUM_OBJ-1:0]  obj_state
);

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10,
    LAND   = 2'b11
  } state_e;

  localparam int Y_TOP = Y_GROUND - OBJ_H + 1;
  localparam int X_HI  = X_MAX - OBJ_W + 1;

  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XHI_S  = 11'(X_HI);
  localparam logic signed [10:0] STEP_S = 11'(STEP_X);
  localparam logic signed [10:0] YTOP_S = 11'(Y_TOP);
  localparam logic signed [10:0] JV_S   = 11'(JUMP_V);
  localparam logic signed [10:0] GRAV_S = 11'(GRAVITY);

  logic sync1_q, sync2_q, sync3_q;
  logic tick_q, tick_d;

  logic [9:0]        x_q [NUM_OBJ];
  logic [9:0]        x_d [NUM_OBJ];
  logic [9:0]        px  [NUM_OBJ];
  logic [9:0]        mx  [NUM_OBJ];
  logic [9:0]        y_q [NUM_OBJ];
  logic [9:0]        y_d [NUM_OBJ];
  logic signed [10:0] vy_q [NUM_OBJ];
  logic signed [10:0] vy_d [NUM_OBJ];
  state_e            st_q [NUM_OBJ];
  state_e            st_d [NUM_OBJ];
  logic [NUM_OBJ-1:0] up_prev_q, up_prev_d;
  logic [NUM_OBJ-1:0] up_h, lf_h, rt_h;

  logic signed [10:0] nx, ny, nvy;

  function automatic logic held(input logic [7:0] code,
                                input logic [8*KEYS-1:0] kc);
    logic r;
    r = 1'b0;
    for (int k = 0; k < KEYS; k++)
      if (code != 8'h00 && kc[8*k +: 8] == code) r = 1'b1;
    return r;
  endfunction

  // Third sync flop doubles as the previous value for edge detect.
  assign tick_d = sync2_q & ~sync3_q;

  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      rt_h[i] = held(KEY_MAP[24*i +: 8], keycodes);
      lf_h[i] = held(KEY_MAP[24*i+8 +: 8], keycodes);
      up_h[i] = held(KEY_MAP[24*i+16 +: 8], keycodes);
    end
  end

  always_comb begin
    nx = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      nx = signed'({1'b0, x_q[i]});
      if (lf_h[i] && !rt_h[i]) begin
        nx = nx - STEP_S;
        if (nx < XMIN_S) nx = XMIN_S;
      end else if (rt_h[i] && !lf_h[i]) begin
        nx = nx + STEP_S;
        if (nx > XHI_S) nx = XHI_S;
      end
      px[i] = nx[9:0];
    end
  end

`ifdef OBJ_COLLISION_EN
  // Check against both the other's old and proposed x so that two objects
  // stepping into each other on the same tick are both held back.
  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      mx[i] = px[i];
      for (int j = 0; j < NUM_OBJ; j++) begin
        if (j != i &&
            12'(y_q[i]) < 12'(y_q[j]) + 12'(OBJ_H) &&
            12'(y_q[j]) < 12'(y_q[i]) + 12'(OBJ_H) &&
            ((12'(px[i]) < 12'(x_q[j]) + 12'(OBJ_W) &&
              12'(x_q[j]) < 12'(px[i]) + 12'(OBJ_W)) ||
             (12'(px[i]) < 12'(px[j]) + 12'(OBJ_W) &&
              12'(px[j]) < 12'(px[i]) + 12'(OBJ_W))))
          mx[i] = x_q[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) mx[i] = px[i];
  end
`endif

  always_comb begin
    ny  = '0;
    nvy = '0;
    up_prev_d = up_prev_q;
    for (int i = 0; i < NUM_OBJ; i++) begin
      x_d[i]  = x_q[i];
      y_d[i]  = y_q[i];
      vy_d[i] = vy_q[i];
      st_d[i] = st_q[i];
      ny  = signed'({1'b0, y_q[i]}) - vy_q[i];
      nvy = vy_q[i] - GRAV_S;
      if (tick_q) begin
        x_d[i] = mx[i];
        up_prev_d[i] = up_h[i];
        unique case (st_q[i])
          GROUND: begin
            if (up_h[i] && !up_prev_q[i]) begin
              st_d[i] = RISE;
              vy_d[i] = JV_S;
            end
          end
          RISE: begin
            if (ny < 0) begin
              y_d[i]  = '0;
              vy_d[i] = '0;
              st_d[i] = FALL;
            end else begin
              y_d[i]  = ny[9:0];
              vy_d[i] = nvy;
              if (nvy <= 0) st_d[i] = FALL;
            end
          end
          FALL: begin
            if (ny >= YTOP_S) begin
              y_d[i]  = 10'(Y_TOP);
              vy_d[i] = '0;
              st_d[i] = LAND;
            end else begin
              y_d[i]  = ny[9:0];
              vy_d[i] = nvy;
            end
          end
          LAND: st_d[i] = GROUND;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      tick_q    <= 1'b0;
      up_prev_q <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i]  <= 10'(X_MIN + 2*i*OBJ_W);
        y_q[i]  <= 10'(Y_TOP);
        vy_q[i] <= '0;
        st_q[i] <= GROUND;
      end
    end else begin
      sync1_q   <= vsync;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      tick_q    <= tick_d;
      up_prev_q <= up_prev_d;
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        vy_q[i] <= vy_d[i];
        st_q[i] <= st_d[i];
      end
    end
  end

  assign frame_tick = tick_q;

  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      obj_x[10*i +: 10]   = x_q[i];
      obj_y[10*i +: 10]   = y_q[i];
      obj_state[2*i +: 2] = st_q[i];
    end
  end

endmodule

// File: tb/tb_object_motion.sv
// tb_object_motion: directed checks of object_motion (tick, walk, jump, reset).
// Ports: none; drives the DUT clock, reset, vsync and keycodes.
module tb_object_motion;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic [31:0] keycodes = '0;
  logic        frame_tick;
  logic [19:0] obj_x, obj_y;
  logic [3:0]  obj_state;

  int n_checks = 0;
  int n_fail   = 0;

  object_motion dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .vsync      (vsync),
    .keycodes   (keycodes),
    .frame_tick (frame_tick),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_state  (obj_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      vsync = 1'b1;
      repeat (5) @(negedge clk);
      vsync = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    vsync = 1'b0;
    keycodes = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obj_x[9:0] !== 10'd0) begin
      n_fail++; $display("FAIL rst_x0: got %0d want 0", obj_x[9:0]);
    end
    n_checks++;
    if (obj_y[9:0] !== 10'd384) begin
      n_fail++; $display("FAIL rst_y0: got %0d want 384", obj_y[9:0]);
    end
    n_checks++;
    if (obj_x[19:10] !== 10'd128) begin
      n_fail++; $display("FAIL rst_x1: got %0d want 128", obj_x[19:10]);
    end
    n_checks++;
    if (obj_y[19:10] !== 10'd384) begin
      n_fail++; $display("FAIL rst_y1: got %0d want 384", obj_y[19:10]);
    end
    n_checks++;
    if (obj_state !== 4'b0000) begin
      n_fail++; $display("FAIL rst_state: got %b want 0000", obj_state);
    end
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL rst_tick: got %b want 0", frame_tick);
    end
  endtask

  task automatic test_frame_tick;
    logic [3:0] seen;
    int extra;
    vsync = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen[k] = frame_tick;
    end
    n_checks++;
    if (seen !== 4'b0100) begin
      n_fail++; $display("FAIL tick_pulse: got %b want 0100", seen);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_tick) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL tick_held: got %0d extra want 0", extra);
    end
    vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_walk;
    keycodes = 32'h0000_0007;
    tick(5);
    n_checks++;
    if (obj_x[9:0] !== 10'd10) begin
      n_fail++; $display("FAIL walk_r: got %0d want 10", obj_x[9:0]);
    end
    n_checks++;
    if (obj_x[19:10] !== 10'd128) begin
      n_fail++; $display("FAIL walk_x1: got %0d want 128", obj_x[19:10]);
    end
    keycodes = 32'h0000_0004;
    tick(6);
    n_checks++;
    if (obj_x[9:0] !== 10'd0) begin
      n_fail++; $display("FAIL walk_lclamp: got %0d want 0", obj_x[9:0]);
    end
    keycodes = 32'h0000_004F;
    tick(300);
    n_checks++;
    if (obj_x[19:10] !== 10'd576) begin
      n_fail++; $display("FAIL walk_rclamp: got %0d want 576", obj_x[19:10]);
    end
    n_checks++;
    if (obj_x[9:0] !== 10'd0) begin
      n_fail++; $display("FAIL walk_x0: got %0d want 0", obj_x[9:0]);
    end
  endtask

  task automatic test_jump;
    keycodes = 32'h0000_001A;
    tick(1);
    n_checks++;
    if (obj_state[1:0] !== 2'b01 || obj_y[9:0] !== 10'd384) begin
      n_fail++;
      $display("FAIL jump_start: got st %b y %0d want 01 384",
               obj_state[1:0], obj_y[9:0]);
    end
    tick(12);
    n_checks++;
    if (obj_state[1:0] !== 2'b10 || obj_y[9:0] !== 10'd306) begin
      n_fail++;
      $display("FAIL jump_apex: got st %b y %0d want 10 306",
               obj_state[1:0], obj_y[9:0]);
    end
    tick(13);
    n_checks++;
    if (obj_state[1:0] !== 2'b11 || obj_y[9:0] !== 10'd384) begin
      n_fail++;
      $display("FAIL jump_land: got st %b y %0d want 11 384",
               obj_state[1:0], obj_y[9:0]);
    end
    tick(1);
    n_checks++;
    if (obj_state[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL jump_ground: got %b want 00", obj_state[1:0]);
    end
    tick(2);
    n_checks++;
    if (obj_state[1:0] !== 2'b00 || obj_y[9:0] !== 10'd384) begin
      n_fail++;
      $display("FAIL jump_noretrig: got st %b y %0d want 00 384",
               obj_state[1:0], obj_y[9:0]);
    end
    n_checks++;
    if (obj_state[3:2] !== 2'b00) begin
      n_fail++; $display("FAIL jump_obj1: got %b want 00", obj_state[3:2]);
    end
  endtask

  task automatic test_independence;
    keycodes = 32'h0000_0007;
    tick(3);
    n_checks++;
    if (obj_x[9:0] !== 10'd6) begin
      n_fail++; $display("FAIL ind_pre: got %0d want 6", obj_x[9:0]);
    end
    keycodes = 32'h0050_0704;
    tick(1);
    n_checks++;
    if (obj_x[19:10] !== 10'd574) begin
      n_fail++; $display("FAIL ind_x1a: got %0d want 574", obj_x[19:10]);
    end
    tick(2);
    n_checks++;
    if (obj_x[9:0] !== 10'd6) begin
      n_fail++; $display("FAIL ind_x0: got %0d want 6", obj_x[9:0]);
    end
    n_checks++;
    if (obj_x[19:10] !== 10'd570) begin
      n_fail++; $display("FAIL ind_x1b: got %0d want 570", obj_x[19:10]);
    end
  endtask

  task automatic test_reset_mid_jump;
    keycodes = 32'h0000_001A;
    tick(3);
    n_checks++;
    if (obj_state[1:0] !== 2'b01 || obj_y[9:0] !== 10'd361) begin
      n_fail++;
      $display("FAIL mid_rise: got st %b y %0d want 01 361",
               obj_state[1:0], obj_y[9:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obj_x[9:0] !== 10'd0 || obj_y[9:0] !== 10'd384) begin
      n_fail++;
      $display("FAIL mid_rst_xy0: got %0d,%0d want 0,384",
               obj_x[9:0], obj_y[9:0]);
    end
    n_checks++;
    if (obj_state !== 4'b0000 || obj_x[19:10] !== 10'd128) begin
      n_fail++;
      $display("FAIL mid_rst_st: got st %b x1 %0d want 0000 128",
               obj_state, obj_x[19:10]);
    end
    keycodes = 32'h0000_0007;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_collision;
    logic [9:0] want;
`ifdef OBJ_COLLISION_EN
    want = 10'd64;
`else
    want = 10'd80;
`endif
    keycodes = 32'h0000_0007;
    tick(40);
    n_checks++;
    if (obj_x[9:0] !== want) begin
      n_fail++; $display("FAIL coll_x0: got %0d want %0d", obj_x[9:0], want);
    end
    n_checks++;
    if (obj_x[19:10] !== 10'd128) begin
      n_fail++; $display("FAIL coll_x1: got %0d want 128", obj_x[19:10]);
    end
  endtask

  initial begin
    test_reset;
    test_frame_tick;
    test_walk;
    test_jump;
    test_independence;
    test_reset_mid_jump;
    test_collision;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
